serial_nibble_rx: RTL and testbench

- Serial-to-parallel front end that assembles WIDTH-bit words from an asynchronous single-wire serial line.
- Produces a one-cycle load strobe and a data word for the downstream enabled register: word_valid drives its en, word drives its d.
- Detects a start bit, samples data mid-bit (LSB first), checks optional even parity and the stop bit, and flags framing and parity errors.

---
 rtl/serial_nibble_rx.sv | 161 ++++++++++++++++
 tb/tb_serial_nibble_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_nibble_rx.sv
// Purpose: oversampled serial receiver; assembles WIDTH-bit LSB-first frames with optional even parity.
// Latency: word_valid/parity_err/frame_err are registered at the stop-bit mid-sample, T+H+(WIDTH+1+PARITY_EN)*CLKS_PER_BIT.
// Backpressure: none; the result strobes are one-cycle pulses and the consumer must accept them when they occur.
module serial_nibble_rx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rx_s;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic             par, par_nxt;
  logic             par_bad, par_bad_nxt;
  logic             valid_nxt, perr_nxt, ferr_nxt;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered result strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sr         <= '0;
      par        <= 1'b0;
      par_bad    <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      sr         <= sr_nxt;
      par        <= par_nxt;
      par_bad    <= par_bad_nxt;
      word       <= word_nxt;
      word_valid <= valid_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  // Next-state and datapath: START samples at the half-bit, later states one full bit apart
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    idx_nxt     = idx;
    sr_nxt      = sr;
    par_nxt     = par;
    par_bad_nxt = par_bad;
    word_nxt    = word;
    valid_nxt   = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt   = START;
          idx_nxt     = '0;
          par_nxt     = 1'b0;
          par_bad_nxt = 1'b0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          // A start bit that is gone by mid-bit is a glitch, not a frame
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt = '0;
          sr_nxt  = {rx_s, sr[WIDTH-1:1]};
          par_nxt = par ^ rx_s;
          if (idx == LAST_BIT) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt     = '0;
          par_bad_nxt = par ^ rx_s;
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            // Return to IDLE immediately so a start bit right after stop is caught
            state_nxt = IDLE;
            if (par_bad) begin
              perr_nxt = 1'b1;
            end else begin
              word_nxt  = sr;
              valid_nxt = 1'b1;
            end
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Purpose: self-checking bench for serial_nibble_rx with default parameters.
// Latency: expects every result pulse 29 clk after the start bit is driven (2 sync + 1 detect + 26).
// Backpressure: n/a; a monitor thread pops expected events from a scoreboard queue.
module tb_serial_nibble_rx;

  localparam int CPB = 4;
  localparam int EVENT_LAT = 29;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] word;
  logic       word_valid, parity_err, frame_err, busy;

  serial_nibble_rx #(.WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .word       (word),
    .word_valid (word_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_VALID, EV_PERR, EV_FERR} ev_t;
  typedef struct {
    ev_t        kind;
    logic [3:0] word;
    int         start;
  } exp_t;
  typedef struct {
    logic [3:0] data;
    logic       pbit;
    logic       stopb;
    int         stop_len;
    ev_t        kind;
    logic [3:0] word;
  } vec_t;

  exp_t exp_q[$];
  int   vcyc_q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Hold rx at level b for n clocks; entered and left 1 time unit after a rising edge
  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input int slen);
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(d[i], CPB);
    hold(p, CPB);
    hold(s, slen);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    vec_t vt[8];
    logic seen;
    int   sp;

    vt[0] = '{4'hA, 1'b0, 1'b1,  4, EV_VALID, 4'hA};
    vt[1] = '{4'hA, 1'b1, 1'b1,  4, EV_PERR,  4'hA};
    vt[2] = '{4'h3, 1'b0, 1'b1,  4, EV_VALID, 4'h3};
    vt[3] = '{4'h5, 1'b0, 1'b0, 32, EV_FERR,  4'h3};
    vt[4] = '{4'h6, 1'b0, 1'b1,  4, EV_VALID, 4'h6};
    vt[5] = '{4'h7, 1'b1, 1'b1,  4, EV_VALID, 4'h7};
    vt[6] = '{4'h0, 1'b1, 1'b1,  4, EV_PERR,  4'h7};
    vt[7] = '{4'hE, 1'b1, 1'b1,  4, EV_VALID, 4'hE};

    fork
      // Scoreboard monitor: every result pulse must match the oldest outstanding frame
      begin
        ev_t  k;
        exp_t e;
        forever begin
          @(negedge clk);
          if (word_valid || parity_err || frame_err) begin
            chk("pulse_onehot", $countones({word_valid, parity_err, frame_err}), 1);
            k = word_valid ? EV_VALID : (parity_err ? EV_PERR : EV_FERR);
            if (word_valid) vcyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
              n_vec++;
              n_miss++;
              $display("FAIL unexpected_event: got kind %0d, expected no pulse (cycle %0d)", k, cyc);
            end else begin
              e = exp_q.pop_front();
              chk("event_kind", k, e.kind);
              chk("event_word", word, e.word);
              chk("event_latency", cyc - e.start, EVENT_LAT);
              chk("busy_at_event", busy, (k == EV_FERR) ? 1 : 0);
            end
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset held with rx toggling: everything stays at reset values
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("reset_outputs", {word, word_valid, parity_err, frame_err, busy}, 0);
      rx = ~rx;
    end
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_after_release", {word, word_valid, parity_err, frame_err, busy}, 0);
    end

    // Table-driven frames
    @(posedge clk);
    #1;
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back('{vt[v].kind, vt[v].word, cyc});
      send_frame(vt[v].data, vt[v].pbit, vt[v].stopb, vt[v].stop_len);
      if (vt[v].kind == EV_FERR) begin
        chk("busy_held_low_line", busy, 1);
        hold(1'b1, 4);
        chk("busy_clear_after_break", busy, 0);
      end
      hold(1'b1, 8);
      drain("frame_event_seen");
    end

    // One-clock glitch: busy pulses, no result pulse
    seen = 1'b0;
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy_seen", seen, 1);
    chk("glitch_busy_clear", busy, 0);
    chk("glitch_word_kept", word, 4'hE);

    // Back-to-back frames with zero idle gap
    @(posedge clk);
    #1;
    vcyc_q.delete();
    exp_q.push_back('{EV_VALID, 4'h1, cyc});
    send_frame(4'h1, 1'b1, 1'b1, 4);
    exp_q.push_back('{EV_VALID, 4'hF, cyc});
    send_frame(4'hF, 1'b0, 1'b1, 4);
    hold(1'b1, 8);
    drain("b2b_events_seen");
    chk("b2b_valid_count", vcyc_q.size(), 2);
    sp = (vcyc_q.size() == 2) ? (vcyc_q[1] - vcyc_q[0]) : -1;
    chk("b2b_spacing", sp, 7 * CPB);

    // Reset asserted mid-frame (during data bit 2 of 4'h9) clears outputs without a clock edge
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    rx = 1'b0;
    #13;
    reset = 1'b0;
    #1;
    chk("async_reset_word", word, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_pulses", {word_valid, parity_err, frame_err}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_reset_outputs", {word, word_valid, parity_err, frame_err, busy}, 0);
    end
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_abort_idle", {word, busy}, 0);

    @(posedge clk);
    #1;
    exp_q.push_back('{EV_VALID, 4'hC, cyc});
    send_frame(4'hC, 1'b0, 1'b1, 4);
    hold(1'b1, 8);
    drain("post_abort_event_seen");
    chk("post_abort_word", word, 4'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
